// File: rtl/sbox_sched.sv
// Time-multiplexes a bank of N_SBOX shared sbox lanes between the round datapath
// (16-byte SubBytes/InvSubBytes) and the key schedule (4-byte forward SubWord).
module sbox_sched #(
  parameter int unsigned N_SBOX   = 4,
  parameter int unsigned SBOX_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_start_i,
  input  logic [127:0]          data_in_i,
  input  logic                  data_decrypt_i,
  output logic                  data_busy_o,
  output logic                  data_done_o,
  output logic [127:0]          data_out_o,
  input  logic                  key_start_i,
  input  logic [31:0]           key_in_i,
  output logic                  key_busy_o,
  output logic                  key_done_o,
  output logic [31:0]           key_out_o,
  output logic [8*N_SBOX-1:0]   sbox_data_o,
  output logic                  sbox_decrypt_o,
  input  logic [8*N_SBOX-1:0]   sbox_data_i
);

  localparam int unsigned KEY_BEATS  = 4 / N_SBOX;
  localparam int unsigned DATA_BEATS = 16 / N_SBOX;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t         r_state, w_next;
  logic           r_job_key;
  logic           r_data_dec;
  logic           r_key_pend, r_data_pend;
  logic           r_key_done, r_data_done;
  logic [31:0]    r_key_in, r_key_out;
  logic [127:0]   r_data_in, r_data_out;
  logic [3:0]     r_beat;
  logic [SBOX_LAT-1:0] r_cap_vld, r_cap_last;
  logic [3:0]     r_cap_beat [SBOX_LAT];

  logic           w_last_beat, w_last_cap, w_launch, w_launch_key;
  logic           w_key_fin, w_data_fin;
  logic [3:0]     w_iss_idx [N_SBOX];
  logic [3:0]     w_cap_idx [N_SBOX];

  assign w_last_beat = r_job_key ? (r_beat == 4'(KEY_BEATS - 1))
                                 : (r_beat == 4'(DATA_BEATS - 1));
  // Capture pipeline tracks each beat SBOX_LAT cycles behind its issue cycle.
  assign w_last_cap  = r_cap_vld[SBOX_LAT-1] & r_cap_last[SBOX_LAT-1];
  assign w_key_fin   = w_last_cap &  r_job_key;
  assign w_data_fin  = w_last_cap & ~r_job_key;

  always_comb begin
    w_next       = r_state;
    w_launch     = 1'b0;
    w_launch_key = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_key_pend) begin
          w_launch     = 1'b1;
          w_launch_key = 1'b1;
        end else if (r_data_pend) begin
          w_launch = 1'b1;
        end
      end
      S_ISSUE: begin
        if (w_last_beat) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        // Chain straight into the other requester's job once the last beat lands.
        if (w_last_cap) begin
          w_next = S_IDLE;
          if (r_job_key && r_data_pend) begin
            w_launch = 1'b1;
          end else if (!r_job_key && r_key_pend) begin
            w_launch     = 1'b1;
            w_launch_key = 1'b1;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (w_launch) w_next = S_ISSUE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    for (int unsigned j = 0; j < N_SBOX; j++) begin
      w_iss_idx[j] = 4'(r_beat * N_SBOX + j);
      w_cap_idx[j] = 4'(r_cap_beat[SBOX_LAT-1] * N_SBOX + j);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_job_key   <= 1'b0;
      r_data_dec  <= 1'b0;
      r_key_pend  <= 1'b0;
      r_data_pend <= 1'b0;
      r_key_done  <= 1'b0;
      r_data_done <= 1'b0;
      r_key_in    <= '0;
      r_key_out   <= '0;
      r_data_in   <= '0;
      r_data_out  <= '0;
      r_beat      <= '0;
      r_cap_vld   <= '0;
      r_cap_last  <= '0;
      for (int unsigned i = 0; i < SBOX_LAT; i++) r_cap_beat[i] <= '0;
    end else begin
      if (w_launch) begin
        r_job_key <= w_launch_key;
        r_beat    <= '0;
      end else if (r_state == S_ISSUE) begin
        r_beat <= r_beat + 4'd1;
      end

      r_cap_vld[0]  <= (r_state == S_ISSUE);
      r_cap_last[0] <= (r_state == S_ISSUE) && w_last_beat;
      r_cap_beat[0] <= r_beat;
      for (int unsigned i = 1; i < SBOX_LAT; i++) begin
        r_cap_vld[i]  <= r_cap_vld[i-1];
        r_cap_last[i] <= r_cap_last[i-1];
        r_cap_beat[i] <= r_cap_beat[i-1];
      end

      if (w_key_fin) begin
        r_key_pend <= 1'b0;
      end else if (key_start_i && !r_key_pend) begin
        r_key_pend <= 1'b1;
        r_key_in   <= key_in_i;
      end

      if (w_data_fin) begin
        r_data_pend <= 1'b0;
      end else if (data_start_i && !r_data_pend) begin
        r_data_pend <= 1'b1;
        r_data_in   <= data_in_i;
        r_data_dec  <= data_decrypt_i;
      end

      r_key_done  <= w_key_fin;
      r_data_done <= w_data_fin;

      if (r_cap_vld[SBOX_LAT-1]) begin
        for (int unsigned j = 0; j < N_SBOX; j++) begin
          if (r_job_key) r_key_out[{w_cap_idx[j][1:0], 3'b000} +: 8] <= sbox_data_i[8*j +: 8];
          else           r_data_out[{w_cap_idx[j], 3'b000} +: 8]     <= sbox_data_i[8*j +: 8];
        end
      end
    end
  end

  always_comb begin
    sbox_data_o = '0;
    if (r_state == S_ISSUE) begin
      for (int unsigned j = 0; j < N_SBOX; j++) begin
        sbox_data_o[8*j +: 8] = r_job_key ? r_key_in[{w_iss_idx[j][1:0], 3'b000} +: 8]
                                          : r_data_in[{w_iss_idx[j], 3'b000} +: 8];
      end
    end
  end

  // Direction is held from first beat through the drain so the sbox output stage sees it too.
  assign sbox_decrypt_o = (r_state != S_IDLE) & ~r_job_key & r_data_dec;
  assign data_busy_o    = r_data_pend;
  assign data_done_o    = r_data_done;
  assign data_out_o     = r_data_out;
  assign key_busy_o     = r_key_pend;
  assign key_done_o     = r_key_done;
  assign key_out_o      = r_key_out;

endmodule

// File: tb/tb_sbox_sched.sv
// Randomized self-checking bench for sbox_sched: AES sbox bank model built from
// GF(2^8) arithmetic plus a single-server, key-first job-timing reference model.
module tb_sbox_sched;

  localparam int unsigned N   = 4;
  localparam int unsigned LAT = 1;
  localparam int KB = 4 / N;
  localparam int DB = 16 / N;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           data_start_i = 1'b0;
  logic [127:0]   data_in_i = '0;
  logic           data_decrypt_i = 1'b0;
  logic           data_busy_o, data_done_o;
  logic [127:0]   data_out_o;
  logic           key_start_i = 1'b0;
  logic [31:0]    key_in_i = '0;
  logic           key_busy_o, key_done_o;
  logic [31:0]    key_out_o;
  logic [8*N-1:0] sbox_data_o;
  logic           sbox_decrypt_o;
  logic [8*N-1:0] sbox_data_i;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sb  [256];
  logic [7:0] isb [256];
  logic [7:0] r_f [N];
  logic [7:0] r_i [N];

  sbox_sched #(.N_SBOX(N), .SBOX_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .data_start_i(data_start_i), .data_in_i(data_in_i), .data_decrypt_i(data_decrypt_i),
    .data_busy_o(data_busy_o), .data_done_o(data_done_o), .data_out_o(data_out_o),
    .key_start_i(key_start_i), .key_in_i(key_in_i),
    .key_busy_o(key_busy_o), .key_done_o(key_done_o), .key_out_o(key_out_o),
    .sbox_data_o(sbox_data_o), .sbox_decrypt_o(sbox_decrypt_o), .sbox_data_i(sbox_data_i)
  );

  always #5 clk = ~clk;

  // Sbox bank: one register stage; direction applied again at the output.
  always @(posedge clk) begin
    for (int j = 0; j < N; j++) begin
      r_f[j] <= sb[sbox_data_o[8*j +: 8]];
      r_i[j] <= isb[sbox_data_o[8*j +: 8]];
    end
  end
  always_comb begin
    sbox_data_i = '0;
    for (int j = 0; j < N; j++) sbox_data_i[8*j +: 8] = sbox_decrypt_o ? r_i[j] : r_f[j];
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic init_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] sub4(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = sb[w[8*b +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] sub16(input logic [127:0] s, input logic dec);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[8*b +: 8] = dec ? isb[s[8*b +: 8]] : sb[s[8*b +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offsets are negedge indices of the start pulses (-1 = none); oxd is a data start
  // issued while the data requester is busy, which must be ignored.
  task automatic run_job(input string nm, input int ok, input int od, input int oxd,
                         input logic [31:0] kin, input logic [127:0] din, input logic dec,
                         output logic [31:0] kv, output logic [127:0] dv);
    int lk, dk, ld, dd, last, kd, ddn, kn, dn;
    logic dh [64];
    logic zh [64];
    logic ok_k, ok_d, ok_z, iss, injob;
    lk = -1; dk = -1; ld = -1; dd = -1;
    // Launch = max(request edge + 1, server free edge); done = launch + beats + latency.
    if (ok >= 0 && (od < 0 || ok <= od)) begin
      lk = ok + 2; dk = lk + KB + LAT;
      if (od >= 0) begin ld = (od + 2 > dk) ? od + 2 : dk; dd = ld + DB + LAT; end
    end else if (od >= 0) begin
      ld = od + 2; dd = ld + DB + LAT;
      if (ok >= 0) begin lk = (ok + 2 > dd) ? ok + 2 : dd; dk = lk + KB + LAT; end
    end
    last = ((dk > dd) ? dk : dd) + 3;
    if (last > 63) last = 63;
    kd = -1; ddn = -1; kn = 0; dn = 0; kv = '0; dv = '0;
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      dh[i] = sbox_decrypt_o;
      zh[i] = (sbox_data_o == '0);
      if (key_done_o) begin
        kn++;
        if (kd < 0) begin kd = i; kv = key_out_o; check({nm, "/kbusy"}, 128'(key_busy_o), 128'(0)); end
      end
      if (data_done_o) begin
        dn++;
        if (ddn < 0) begin ddn = i; dv = data_out_o; check({nm, "/dbusy"}, 128'(data_busy_o), 128'(0)); end
      end
      key_start_i    = (i == ok);
      key_in_i       = kin;
      data_start_i   = (i == od) || (i == oxd);
      data_in_i      = (i == oxd) ? ~din : din;
      data_decrypt_i = (i == oxd) ? ~dec : dec;
    end
    key_start_i = 1'b0; data_start_i = 1'b0;
    if (ok >= 0) begin
      check({nm, "/klat"}, 128'(kd), 128'(dk));
      check({nm, "/kout"}, 128'(kv), 128'(sub4(kin)));
      check({nm, "/kpulses"}, 128'(kn), 128'(1));
    end
    if (od >= 0) begin
      check({nm, "/dlat"}, 128'(ddn), 128'(dd));
      check({nm, "/dout"}, dv, sub16(din, dec));
      check({nm, "/dpulses"}, 128'(dn), 128'(1));
    end
    ok_k = 1'b1; ok_d = 1'b1; ok_z = 1'b1;
    for (int c = 0; c <= last; c++) begin
      iss   = (lk >= 0 && c >= lk && c < lk + KB) || (ld >= 0 && c >= ld && c < ld + DB);
      injob = (lk >= 0 && c >= lk && c < dk) || (ld >= 0 && c >= ld && c < dd);
      if (lk >= 0 && c >= lk && c < dk && dh[c] !== 1'b0) ok_k = 1'b0;
      if (ld >= 0 && c >= ld && c < dd && dh[c] !== dec) ok_d = 1'b0;
      if (!injob && dh[c] !== 1'b0) ok_d = 1'b0;
      if (!iss && !zh[c]) ok_z = 1'b0;
    end
    if (ok >= 0) check({nm, "/kdir"}, 128'(ok_k), 128'(1));
    if (od >= 0) check({nm, "/ddir"}, 128'(ok_d), 128'(1));
    check({nm, "/idlezero"}, 128'(ok_z), 128'(1));
  endtask

  initial begin
    logic [31:0]  kv;
    logic [127:0] dv, s0, s1, rd;
    int mode, d, nd;
    init_tables();
    s0 = 128'h08_48_f8_e9_2a_8d_c6_9a_2b_e2_f4_a0_be_e3_3d_19;
    s1 = 128'h30_52_41_1e_e5_5d_b4_b8_f1_98_bf_e0_ae_11_27_d4;

    repeat (3) @(negedge clk);
    check("rst/data", {data_busy_o, data_done_o, data_out_o[125:0]}, '0);
    check("rst/misc", {data_out_o[127:126], key_busy_o, key_done_o, key_out_o, sbox_data_o, sbox_decrypt_o}, '0);
    reset = 1'b1;
    @(negedge clk);

    run_job("t1", 0, -1, -1, 32'h093c4fcf, '0, 1'b0, kv, dv);
    check("t1/kconst", 128'(kv), 128'(32'h01eb848a));
    run_job("t2", -1, 0, -1, '0, s0, 1'b0, kv, dv);
    check("t2/dconst", dv, s1);
    run_job("t3", -1, 0, -1, '0, s1, 1'b1, kv, dv);
    check("t3/dconst", dv, s0);
    run_job("t4", 0, 0, -1, $urandom, rnd128(), 1'b1, kv, dv);
    run_job("t5", 2, 0, -1, 32'h0, rnd128(), 1'b1, kv, dv);
    check("t5/kconst", 128'(kv), 128'(32'h63636363));
    run_job("busyign", -1, 0, 2, '0, rnd128(), 1'b0, kv, dv);

    // Reset in the middle of a data job's issue phase.
    rd = rnd128();
    data_start_i = 1'b1; data_in_i = rd; data_decrypt_i = 1'b1;
    @(negedge clk); data_start_i = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6/data", {data_busy_o, data_done_o, data_out_o[125:0]}, '0);
    check("t6/misc", {data_out_o[127:126], key_busy_o, key_done_o, key_out_o, sbox_data_o, sbox_decrypt_o}, '0);
    @(negedge clk);
    reset = 1'b1;
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (data_done_o || data_busy_o) nd++;
    end
    check("t6/nodone", 128'(nd), 128'(0));
    run_job("t6k", 0, -1, -1, $urandom, '0, 1'b0, kv, dv);

    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 4);
      d    = $urandom_range(1, 8);
      case (mode)
        0: run_job("rk",  0, -1, -1, $urandom, '0, 1'b0, kv, dv);
        1: run_job("rd", -1,  0, (d < 6) ? d : -1, '0, rnd128(), 1'($urandom), kv, dv);
        2: run_job("rkd", 0,  0, -1, $urandom, rnd128(), 1'($urandom), kv, dv);
        3: run_job("rdk", d,  0, -1, $urandom, rnd128(), 1'($urandom), kv, dv);
        default: run_job("rkd2", 0, d % 4, -1, $urandom, rnd128(), 1'($urandom), kv, dv);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
